// File: rtl/demux_pkg.sv
// Shared constants and slot-state type for the demux router.
package demux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_OUT  = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice feeding one demux output; data reads zero while empty.
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              free,
  output slot_state_t       state
);

  slot_state_t       state_next;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A drain in the same cycle as a load keeps the slot FULL with the new word.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (load)           state_next = FULL;
      FULL:  if (ready && !load) state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= word;
    end
  end

  assign data = (state == FULL) ? data_q : '0;
  assign free = (state == EMPTY) || ready;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-N demultiplexer with a one-entry slot per output and broadcast.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// ready never depends on valid, and a producer holds its payload while valid && !ready.
module demux_router
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_sel
);

  localparam int                SELX_W  = SEL_W + 1;
  localparam logic [SELX_W-1:0] N_OUT_X = SELX_W'(N_OUT);

  logic [N_OUT-1:0] target;
  logic [N_OUT-1:0] free;
  logic [N_OUT-1:0] load;
  logic             sel_bad;
  logic             accept;
  slot_state_t      slot_state [N_OUT];

  // An out-of-range unicast has no target: it is accepted and dropped.
  assign sel_bad  = !in_bcast && ({1'b0, in_sel} >= N_OUT_X);
  assign in_ready = &(~target | free);
  assign accept   = in_valid && in_ready;
  assign load     = accept ? target : '0;

  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    assign target[i]    = in_bcast || (in_sel == SEL_W'(i));
    assign out_valid[i] = (slot_state[i] == FULL);

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .word  (in_data),
      .ready (out_ready[i]),
      .data  (out_data[i*DATA_W +: DATA_W]),
      .free  (free[i]),
      .state (slot_state[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel <= 1'b0;
    end else if (accept && sel_bad) begin
      err_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_router.sv
// Directed and random checks of demux_router against a per-output slot model.
module tb_demux_router;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, in_bcast, err_sel;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic [N-1:0]   out_valid, out_ready;
  logic [N*W-1:0] out_data;

  logic            in_valid3, in_ready3, in_bcast3, err_sel3;
  logic [W-1:0]    in_data3;
  logic [1:0]      in_sel3;
  logic [N3-1:0]   out_valid3, out_ready3;
  logic [N3*W-1:0] out_data3;

  demux_router #(.DATA_W(W), .N_OUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_sel(err_sel)
  );

  demux_router #(.DATA_W(W), .N_OUT(N3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .in_bcast(in_bcast3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .err_sel(err_sel3)
  );

  int passed = 0;
  int total  = 0;

  // Reference: each output is a FIFO of depth one (held word + occupancy).
  logic         m_full [N];
  logic [W-1:0] m_data [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] m_valid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_full[i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] m_odata();
    logic [N*W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) if (m_full[i]) d[i*W +: W] = m_data[i];
    return d;
  endfunction

  // Called at a negedge: drive, check in_ready, clock, check registered outputs.
  task automatic step(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                      input logic b, input logic [N-1:0] r, output logic acc);
    logic         exp_rdy;
    logic [N-1:0] tgt;
    in_valid = v; in_data = d; in_sel = s; in_bcast = b; out_ready = r;
    #1;
    tgt = b ? {N{1'b1}} : (N'(1) << s);
    exp_rdy = 1'b1;
    for (int i = 0; i < N; i++) if (tgt[i] && m_full[i] && !r[i]) exp_rdy = 1'b0;
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc && tgt[i]) begin
        m_full[i] = 1'b1;
        m_data[i] = d;
      end else if (m_full[i] && r[i]) begin
        m_full[i] = 1'b0;
      end
    end
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid()));
    chk("out_data", 64'(out_data), 64'(m_odata()));
  endtask

  initial begin
    logic         acc, v, hb, held;
    logic [W-1:0] hd;
    logic [1:0]   hs;
    int           n_acc;

    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
    end
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; in_sel = '0; in_bcast = 0; out_ready = '0;
    in_valid3 = 0; in_data3 = '0; in_sel3 = '0; in_bcast3 = 0; out_ready3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_err_sel", {63'd0, err_sel}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unicast to output 2, then drain.
    step(1, 8'hA5, 2'd2, 0, 4'b1111, acc);
    chk("uni_slot2", 64'(out_data[2*W +: W]), 64'hA5);
    step(0, 8'h00, 2'd0, 0, 4'b1111, acc);

    // Backpressure on output 1 while output 3 keeps flowing.
    step(1, 8'h11, 2'd1, 0, 4'b1101, acc);
    step(1, 8'h33, 2'd3, 0, 4'b1101, acc);
    chk("bp_sel3_acc", {63'd0, acc}, 64'd1);
    step(1, 8'h22, 2'd1, 0, 4'b1101, acc);
    chk("bp_refused", {63'd0, acc}, 64'd0);
    step(1, 8'h22, 2'd1, 0, 4'b1101, acc);
    chk("bp_slot1_held", 64'(out_data[1*W +: W]), 64'h11);
    step(1, 8'h22, 2'd1, 0, 4'b1111, acc);
    chk("bp_slot1_next", 64'(out_data[1*W +: W]), 64'h22);
    step(0, 8'h00, 2'd0, 0, 4'b1111, acc);

    // Broadcast waits for a stalled full slot 0, then lands everywhere at once.
    step(1, 8'h77, 2'd0, 0, 4'b0000, acc);
    step(1, 8'h3C, 2'd2, 1, 4'b1110, acc);
    chk("bc_blocked", {63'd0, acc}, 64'd0);
    step(1, 8'h3C, 2'd2, 1, 4'b1111, acc);
    chk("bc_all", 64'(out_data), 64'h3C3C3C3C);
    chk("bc_valid", 64'(out_valid), 64'hF);
    step(0, 8'h00, 2'd0, 0, 4'b1111, acc);

    // Out-of-range select on the three-output instance.
    in_valid3 = 1; in_data3 = 8'h99; in_sel3 = 2'd3; in_bcast3 = 0; out_ready3 = 3'b000;
    #1;
    chk("bad_in_ready", {63'd0, in_ready3}, 64'd1);
    @(negedge clk);
    in_valid3 = 0;
    chk("bad_out_valid", 64'(out_valid3), 64'd0);
    chk("bad_err_set", {63'd0, err_sel3}, 64'd1);
    in_valid3 = 1; in_data3 = 8'h42; in_sel3 = 2'd2;
    @(negedge clk);
    in_valid3 = 0;
    chk("n3_valid", 64'(out_valid3), 64'b100);
    chk("n3_data", 64'(out_data3), 64'h420000);
    chk("bad_err_sticky", {63'd0, err_sel3}, 64'd1);

    // Random streaming; a refused word is held stable until accepted.
    n_acc = 0; held = 0; v = 0; hd = '0; hs = '0; hb = 0;
    for (int c = 0; c < 800 && n_acc < 100; c++) begin
      if (!held) begin
        v  = ($urandom_range(0, 3) != 0);
        hd = W'($urandom);
        hs = 2'($urandom_range(0, 3));
        hb = ($urandom_range(0, 7) == 0);
      end
      step(v, hd, hs, hb, N'($urandom), acc);
      held = v && !acc;
      if (acc) n_acc++;
    end
    chk("stream_count", 64'(n_acc), 64'd100);

    // Asynchronous reset between clock edges with words held.
    step(1, 8'h5A, 2'd1, 0, 4'b0000, acc);
    step(1, 8'hC3, 2'd0, 0, 4'b0000, acc);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_err3", {63'd0, err_sel3}, 64'd0);
    chk("arst_valid3", 64'(out_valid3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'hE1, 2'd3, 0, 4'b1111, acc);
    chk("post_rst_slot3", 64'(out_data[3*W +: W]), 64'hE1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/demux_router.md
# demux_router

Parametrised, registered 1-to-N demultiplexer with valid/ready flow control per output. It routes one input word to a single selected output, or to all outputs at once in broadcast mode. Each output has a one-entry holding slot, so a stalled consumer blocks only traffic aimed at it. The block is the buffered successor of the team's combinational 1-to-4 bit demux and sits between a single producer and N independent consumers.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- N_OUT, 4, number of outputs (2..16; need not be a power of two)
- SEL_W, $clog2(N_OUT), select width (derived; do not override)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block accepts the word this cycle
- in_data  in  DATA_W  payload
- in_sel  in  SEL_W  destination index
- in_bcast  in  1  1 = deliver to every output; in_sel is ignored
- out_valid  out  N_OUT  per-output slot full
- out_ready  in  N_OUT  per-output consumer accept
- out_data  out  N_OUT*DATA_W  slot i occupies bits [i*DATA_W +: DATA_W]
- err_sel  out  1  sticky flag: a word with in_sel ≥ N_OUT was accepted

## Operation
- Per-output slot states: EMPTY, FULL. A slot moves EMPTY→FULL on a load and FULL→EMPTY on out_valid & out_ready with no load. It stays FULL on drain plus load in the same cycle.
- Target set T: all outputs if in_bcast, else {in_sel}. If in_sel ≥ N_OUT and in_bcast=0, T is empty.
- Slot i is "free" when it is EMPTY or when out_ready[i]=1 this cycle.
- in_ready = AND over T of free. An empty T gives in_ready=1.
- Accept = in_valid & in_ready. On accept, every slot in T loads in_data.
- Accept with empty T discards the word and sets err_sel. err_sel clears only on reset.
- Broadcast is all-or-nothing. No partial delivery occurs, and the word waits until every slot is free.
- out_data of an EMPTY slot is forced to all-zero. Non-selected outputs therefore read 0, as in the legacy demux.
- Producer rule: in_data, in_sel and in_bcast stay stable while in_valid=1 and in_ready=0. The block does not check this rule.
- No ordering is guaranteed across different outputs. Per output, order is strictly FIFO (depth 1).

## Timing
- Reset (async assert, sync release): out_valid=0, out_data=0, err_sel=0, all slots EMPTY. in_ready is combinational and may be 1 during reset, but no load occurs while rst_n=0.
- Latency is 1 cycle: a word accepted at edge k shows on out_valid/out_data after edge k.
- Throughput is 1 word/cycle per output while out_ready is held 1, including back-to-back words to the same output.
- Combinational paths:
  - in_ready depends on in_valid-independent inputs in_sel, in_bcast, out_ready and slot state.
  - out_valid and out_data are registered only.
- Simultaneous drain and load on slot i: new data replaces old, and out_valid stays 1.
- Reset mid-operation: all held words are lost and err_sel clears.

## Structure
- Package demux_pkg holds the default DATA_W and N_OUT constants and a slot-state enum (EMPTY, FULL).
- Sub-module demux_slot implements one one-entry register slice with load, drain, state, zero-masked data and a free output. It is instantiated N_OUT times in a generate loop.
- The top level holds the target decode, the in_ready reduction and the err_sel flop.

## Test plan
- Reset: assert rst_n=0 mid-traffic → out_valid=0000, out_data=0, err_sel=0 asynchronously.
- Unicast: in_sel=2, in_data=0xA5, out_ready=1111 → next cycle out_valid=0100, slot 2=0xA5, other slots=0x00.
- Backpressure: out_ready[1]=0, two words to sel=1 (0x11, 0x22) → 0x11 accepted, in_ready=0 for 0x22. Meanwhile a word to sel=3 is accepted. Raising out_ready[1] → 0x11 drains, then 0x22 appears.
- Broadcast: in_bcast=1, in_data=0x3C, out_ready[0]=0 with slot 0 FULL → in_ready=0. Release out_ready[0] → one cycle later all four slots=0x3C.
- Bad select: N_OUT=3, in_sel=3 → accepted (in_ready=1), no out_valid change, err_sel=1 until reset.
- Streaming: 100 random words to random sel with random out_ready → per-output data order matches a scoreboard, no loss or duplication.
